// File: rtl/beamscaler_pkg.sv
// Shared definitions for the beam-scaler WISHBONE reader.
// Holds the reader FSM encoding, the error fill word and the default sweep size.
package beamscaler_pkg;

    // Reader FSM states: wait for a bank, fetch one word over WISHBONE, push it on the stream.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    // Word emitted in place of scaler data when the bus reports an error or times out.
    localparam logic [31:0] FILL_WORD = 32'hFFFF_FFFF;

    // Number of 32-bit scaler words read per sweep when the instance does not override it.
    localparam int DEFAULT_NWORDS = 64;

    // Word index covers up to 1024 words; the byte address appends two zero bits.
    localparam int IDX_W = 10;
    localparam int ADR_W = 12;

    // Ack-wait counter width (TIMEOUT is at most 255).
    localparam int TMO_W = 8;

endpackage

// File: rtl/beamscaler_wb_reader.sv
// Beam-scaler WISHBONE reader.
// On a bank-complete pulse it sweeps NWORDS 32-bit words from the scaler over a
// single-outstanding WISHBONE initiator and forwards each word as one stream beat.
// Optional feature macro: BEAMSCALER_RD_TIMEOUT_EN adds an ack-wait timeout that
// substitutes the fill word (with the error flag) when the target never answers.
//
// Stream handshake: a beat is transferred on a rising edge where m_tvalid and
// m_tready are both high. Once m_tvalid rises, m_tdata, m_tlast and m_tuser stay
// constant and m_tvalid stays high until that transfer; m_tvalid never depends
// on m_tready.
module beamscaler_wb_reader
    import beamscaler_pkg::*;
#(
    parameter int NWORDS  = DEFAULT_NWORDS,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             done_i,
    input  logic             bank_i,

    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,

    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic [1:0]       m_tuser,
    input  logic             m_tready,

    output logic             busy_o,
    output logic             overrun_o,
    output logic [1:0]       dbg_state_o
);

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NWORDS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_index;
    logic              r_bank;
    logic [31:0]       r_data;
    logic              r_err;
    logic              r_overrun;

    logic              w_last;
    logic              w_timeout;
    logic              w_resp;
    logic              w_fill;
    logic              w_unused;

    // Retry is not supported by this initiator; the input is accepted and ignored.
    assign w_unused = wb_rty_i;

    assign w_last = (r_index == LP_LAST_IDX);

`ifdef BEAMSCALER_RD_TIMEOUT_EN
    localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Count REQ cycles without a response; leaving REQ rearms it so every entry starts at zero.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (r_state != ST_REQ)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // The TIMEOUT-th REQ cycle with no ack/err ends the bus cycle with a fill beat.
    assign w_timeout = (r_state == ST_REQ) && (r_tmo_cnt == LP_TMO_LAST);
`else
    logic [TMO_W-1:0] w_unused_tmo;

    // Without the timeout the bus cycle waits for the target indefinitely.
    assign w_timeout    = 1'b0;
    assign w_unused_tmo = TMO_W'(TIMEOUT);
`endif

    // Any termination of the current bus cycle; err (or timeout) forces the fill word.
    assign w_resp = wb_ack_i || wb_err_i || w_timeout;
    assign w_fill = wb_err_i || (w_timeout && !wb_ack_i);

    // State register; reset abandons any sweep in progress.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one bus read, then one stream beat, per word.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (done_i) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_resp) begin
                    w_next_state = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (m_tready) begin
                    w_next_state = w_last ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Word index, latched bank, captured beat and overrun pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_index   <= '0;
            r_bank    <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // A bank completion outside IDLE is dropped and flagged for one cycle.
            r_overrun <= done_i && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (done_i) begin
                        r_bank  <= bank_i;
                        r_index <= '0;
                    end
                end
                ST_REQ: begin
                    if (w_resp) begin
                        r_data <= w_fill ? FILL_WORD : wb_dat_i;
                        r_err  <= w_fill;
                    end
                end
                ST_PUSH: begin
                    if (m_tready && !w_last) begin
                        r_index <= r_index + 1'b1;
                    end
                end
                default: begin
                    r_index <= '0;
                end
            endcase
        end
    end

    // Bus and stream outputs decode straight from the state, so cyc and tvalid are exclusive.
    assign wb_cyc_o    = (r_state == ST_REQ);
    assign wb_stb_o    = (r_state == ST_REQ);
    assign wb_we_o     = 1'b0;
    assign wb_adr_o    = (r_state == ST_REQ) ? {r_index, 2'b00} : '0;

    assign m_tvalid    = (r_state == ST_PUSH);
    assign m_tlast     = (r_state == ST_PUSH) && w_last;
    assign m_tdata     = r_data;
    assign m_tuser     = {r_err, r_bank};

    assign busy_o      = (r_state != ST_IDLE);
    assign overrun_o   = r_overrun;
    assign dbg_state_o = r_state;

endmodule

// File: doc/beamscaler_wb_reader.md
BEAMSCALER_WB_READER -- requirements
Module: beamscaler_wb_reader

Interface
REQ-001 SHALL have parameter NWORDS, default 64: number of 32-bit scaler words read per sweep, range 1..1024.
REQ-002 SHALL have parameter TIMEOUT, default 255: ack-wait limit in cycles, range 1..255; used only when the timeout feature is enabled.
REQ-003 SHALL have port wb_clk_i  in  1: the only clock. Reset is synchronous and active-high.
REQ-004 SHALL have port wb_rst_i  in  1: synchronous, active-high reset.
REQ-005 SHALL have port done_i  in  1: single-cycle pulse; a scaler bank has completed.
REQ-006 SHALL have port bank_i  in  1: number of the completed bank, valid with done_i.
REQ-007 SHALL have WISHBONE initiator outputs wb_cyc_o 1, wb_stb_o 1, wb_we_o 1 (constant 0), wb_adr_o 12.
REQ-008 SHALL have WISHBONE initiator inputs wb_dat_i 32, wb_ack_i 1, wb_err_i 1, wb_rty_i 1 (ignored).
REQ-009 SHALL have stream outputs m_tdata 32, m_tvalid 1, m_tlast 1, m_tuser 2 ({error, bank}), and stream input m_tready 1.
REQ-010 SHALL have outputs busy_o 1 (high while not IDLE) and overrun_o 1 (single-cycle pulse).

Function
REQ-011 SHALL implement the FSM states IDLE, REQ and PUSH.
REQ-012 IDLE: SHALL latch bank_i, clear the word index to 0 and enter REQ at the next edge when done_i=1.
REQ-013 REQ: SHALL drive wb_cyc_o=wb_stb_o=1 and wb_adr_o={index[9:0],2'b00}.
REQ-014 REQ: on wb_ack_i, SHALL register m_tdata=wb_dat_i and tuser error=0, deassert cyc/stb, and enter PUSH at the next edge.
REQ-015 REQ: on wb_err_i, SHALL behave as on ack, except m_tdata=32'hFFFF_FFFF and tuser error=1.
REQ-016 REQ: if ack and err are asserted together, SHALL give err priority.
REQ-017 PUSH: SHALL assert m_tvalid.
REQ-018 PUSH: SHALL assert m_tlast when index==NWORDS-1.
REQ-019 PUSH: SHALL hold m_tdata, m_tlast and m_tuser stable until m_tready.
REQ-020 PUSH: on a tvalid&tready handshake, SHALL go to IDLE if this is the last word, otherwise increment the index and return to REQ.
REQ-021 SHALL have latency: done_i at cycle 0 gives stb at cycle 1; ack at cycle N gives tvalid at cycle N+1.
REQ-022 SHALL pulse overrun_o for one cycle and discard the request when done_i arrives in any state other than IDLE, including the cycle of the final handshake.
REQ-023 SHALL never have wb_cyc_o and m_tvalid high in the same cycle.
REQ-024 SHALL hold wb_adr_o at 0 in IDLE.

Reset
REQ-025 On wb_rst_i, SHALL at the next edge set state=IDLE, index=0, and cyc, stb, m_tvalid, m_tlast, overrun_o, busy_o, m_tdata, m_tuser all 0.
REQ-026 Reset mid-sweep SHALL abandon the sweep; a dropped in-flight WB cycle or stream beat is accepted behaviour.
REQ-027 SHALL ignore done_i coincident with wb_rst_i.

Configuration
REQ-028 With macro BEAMSCALER_RD_TIMEOUT_EN defined, SHALL count cycles in REQ without ack/err.
REQ-029 With BEAMSCALER_RD_TIMEOUT_EN defined, on reaching TIMEOUT SHALL drop cyc/stb and emit m_tdata=32'hFFFF_FFFF with tuser error=1 via PUSH.
REQ-030 With BEAMSCALER_RD_TIMEOUT_EN defined, SHALL clear the timeout counter on each entry to REQ.
REQ-031 Without BEAMSCALER_RD_TIMEOUT_EN, REQ SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-032 SHALL place the state enum, the fill constant 32'hFFFF_FFFF and the default NWORDS in shared package beamscaler_pkg.
REQ-033 SHALL be a single module with no sub-module.

Verification
REQ-034 NWORDS=4, target model acks 3 cycles after stb with data 0x100+index, m_tready=1, done_i with bank_i=1 -> adr 0,4,8,C; 4 beats 0x100..0x103; tlast on beat 4 only; tuser=2'b01.
REQ-035 m_tready low for 5 cycles on beat 2 -> tdata/tlast/tuser held; no WB cycle issued until the handshake.
REQ-036 done_i pulsed during word 2 and again on the final handshake cycle -> two overrun_o pulses; no second sweep; busy_o falls after the last beat.
REQ-037 wb_err_i on word 1 -> beat 1 = 0xFFFF_FFFF with tuser error=1; the sweep continues to completion.
REQ-038 With BEAMSCALER_RD_TIMEOUT_EN and TIMEOUT=8, target never acks word 0 -> cyc drops after 8 cycles, fill beat emitted, word 1 requested.
REQ-039 wb_rst_i asserted during REQ of word 2 -> next cycle cyc/stb/tvalid/busy_o=0; a new done_i restarts at adr 0.
